// File: rtl/ascon_pack.sv
// Shared types and constants for the iterative Ascon permutation.
package ascon_pack;

  localparam int ROUNDS_A_DEF = 12;
  localparam int ROUNDS_B_DEF = 6;
  localparam int LAST_ROUND   = 11;

  // x0 is word [0], x4 is word [4]
  typedef logic [4:0][63:0] type_state;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  // Right-rotation pair (a, b) used by the diffusion layer for each word
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  // Round constant derived from the absolute round index
  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'd15 - r, r};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/permutation_round.sv
// One combinational Ascon round: constant addition, S-box layer, diffusion.
module permutation_round
  import ascon_pack::*;
(
  input  type_state   state_i,
  input  logic [3:0]  round_i,
  output type_state   state_o
);

  type_state   s_c;
  type_state   s_s;
  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  // constant addition into the low byte of x2
  always_comb begin
    s_c          = state_i;
    s_c[2][7:0]  = state_i[2][7:0] ^ round_const(round_i);
  end

  // bitsliced 5-bit S-box over all 64 columns
  always_comb begin
    x0 = s_c[0];
    x1 = s_c[1];
    x2 = s_c[2];
    x3 = s_c[3];
    x4 = s_c[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    s_s = {x4, x3, x2, x1, x0};
  end

  // linear diffusion, one rotation pair per word
  always_comb begin
    state_o = s_s;
    for (int i = 0; i < 5; i++) begin
      state_o[i] = s_s[i] ^ ror64(s_s[i], ROT_A[i]) ^ ror64(s_s[i], ROT_B[i]);
    end
  end

endmodule

// File: rtl/permutation_engine.sv
// Iterative Ascon p^a / p^b: one round per clock on a registered 320-bit state.
//
// state | meaning
// IDLE  | waiting for start_i; state_o holds the last result
// RUN   | applying round r each edge until r reaches 11
module permutation_engine
  import ascon_pack::*;
#(
  parameter int ROUNDS_A = ROUNDS_A_DEF,
  parameter int ROUNDS_B = ROUNDS_B_DEF
) (
  input  logic        clock_i,
  input  logic        resetb_i,
  input  logic        start_i,
  input  logic        mode_i,
  input  type_state   state_i,
  output type_state   state_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [3:0]  round_o
);

  if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_rounds_a
    $error("ROUNDS_A must be in 1..12");
  end
  if (ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_rounds_b
    $error("ROUNDS_B must be in 1..12");
  end

  // Shorter permutations start part-way so the last round is always r=11
  localparam logic [3:0] FIRST_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] FIRST_B = 4'(12 - ROUNDS_B);
  localparam logic [3:0] LAST_R  = 4'(LAST_ROUND);

  fsm_e        fsm_q, fsm_d;
  type_state   state_q, state_d;
  type_state   round_out;
  logic [3:0]  round_q, round_d;
  logic        done_q, done_d;

  permutation_round u_round (
    .state_i (state_q),
    .round_i (round_q),
    .state_o (round_out)
  );

  // register update with synchronous reset
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  // next-state, round counter and state mux
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d = state_i;
          round_d = mode_i ? FIRST_B : FIRST_A;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = round_out;
        if (round_q == LAST_R) begin
          fsm_d  = IDLE;
          done_d = 1'b1;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign state_o = state_q;
  assign busy_o  = (fsm_q == RUN);
  assign done_o  = done_q;
  assign round_o = round_q;

  // the counter holds at 11 on the final round, so 12..15 never appear
  a_round_range : assert property (@(posedge clock_i) disable iff (!resetb_i)
    round_q <= LAST_R);

endmodule

// File: tb/tb_permutation_engine.sv
// Directed bench for permutation_engine with an independent LUT-based Ascon model.
module tb_permutation_engine;
  import ascon_pack::*;

  logic        clock_i = 1'b0;
  logic        resetb_i;
  logic        start_i;
  logic        mode_i;
  type_state   state_in;
  type_state   state_out;
  logic        busy;
  logic        done;
  logic [3:0]  round;

  int checks   = 0;
  int failures = 0;

  always #5 clock_i = ~clock_i;

  permutation_engine dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .state_i  (state_in),
    .state_o  (state_out),
    .busy_o   (busy),
    .done_o   (done),
    .round_o  (round)
  );

  localparam logic [7:0] CONST_TAB [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                            8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
  localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                       5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                       5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                       5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic type_state model_round(input type_state s, input int r);
    type_state  a, b;
    logic [4:0] v;
    a = s;
    a[2][7:0] = a[2][7:0] ^ CONST_TAB[r];
    b = '0;
    for (int j = 0; j < 64; j++) begin
      v = {a[0][j], a[1][j], a[2][j], a[3][j], a[4][j]};
      v = SBOX[v];
      b[0][j] = v[4];
      b[1][j] = v[3];
      b[2][j] = v[2];
      b[3][j] = v[1];
      b[4][j] = v[0];
    end
    for (int i = 0; i < 5; i++) a[i] = b[i] ^ rotr(b[i], RA[i]) ^ rotr(b[i], RB[i]);
    return a;
  endfunction

  function automatic type_state model_perm(input type_state s, input int n);
    type_state t;
    t = s;
    for (int r = 12 - n; r < 12; r++) t = model_round(t, r);
    return t;
  endfunction

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic      mode;
    type_state init;
    int        first_r;
    int        n_rounds;
  } vec_t;

  vec_t vecs [4];

  task automatic run_vec(input int k);
    type_state exp_s, res;
    int busy_cnt, done_cnt, done_at, exp_r;
    logic round_ok;
    exp_s = model_perm(vecs[k].init, vecs[k].n_rounds);
    @(negedge clock_i);
    start_i  = 1'b1;
    mode_i   = vecs[k].mode;
    state_in = vecs[k].init;
    @(negedge clock_i);
    start_i  = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1; round_ok = 1'b1;
    exp_r    = vecs[k].first_r;
    res      = '0;
    for (int c = 1; c <= vecs[k].n_rounds + 3; c++) begin
      if (busy) begin
        busy_cnt++;
        if (round !== 4'(exp_r)) round_ok = 1'b0;
        exp_r++;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          res     = state_out;
        end
      end
      if (c == 2) start_i = 1'b1;
      if (c == 3) start_i = 1'b0;
      @(negedge clock_i);
    end
    check($sformatf("vec%0d busy_cycles", k), 320'(busy_cnt), 320'(vecs[k].n_rounds));
    check($sformatf("vec%0d round_seq", k), 320'(round_ok), 320'(1));
    check($sformatf("vec%0d done_pulses", k), 320'(done_cnt), 320'(1));
    check($sformatf("vec%0d done_latency", k), 320'(done_at), 320'(vecs[k].n_rounds + 1));
    check($sformatf("vec%0d result", k), res, exp_s);
    check($sformatf("vec%0d result_hold", k), state_out, exp_s);
  endtask

  initial begin
    type_state a, b, r1, r2;
    int dones, busy_cnt, d1, d2, found;

    vecs[0].mode = 1'b0; vecs[0].init = '0; vecs[0].first_r = 0; vecs[0].n_rounds = 12;
    vecs[1].mode = 1'b1; vecs[1].first_r = 6; vecs[1].n_rounds = 6;
    vecs[1].init[0] = 64'h80400c0600000000;
    vecs[1].init[1] = 64'h0001020304050607;
    vecs[1].init[2] = 64'h08090a0b0c0d0e0f;
    vecs[1].init[3] = 64'h0001020304050607;
    vecs[1].init[4] = 64'h08090a0b0c0d0e0f;
    vecs[2].mode = 1'b0; vecs[2].first_r = 0; vecs[2].n_rounds = 12;
    vecs[2].init[0] = 64'h0123456789abcdef;
    vecs[2].init[1] = 64'hfedcba9876543210;
    vecs[2].init[2] = 64'hdeadbeefcafef00d;
    vecs[2].init[3] = 64'h0000000000000000;
    vecs[2].init[4] = 64'hffffffffffffffff;
    vecs[3].mode = 1'b1; vecs[3].init = '1; vecs[3].first_r = 6; vecs[3].n_rounds = 6;

    resetb_i = 1'b0;
    start_i  = 1'b0;
    mode_i   = 1'b0;
    state_in = '1;
    @(negedge clock_i);
    check("reset state_o", state_out, '0);
    check("reset busy", 320'(busy), 320'(0));
    check("reset done", 320'(done), 320'(0));
    check("reset round", 320'(round), 320'(0));
    resetb_i = 1'b1;

    for (int r = 0; r < 12; r++)
      check($sformatf("round_const r%0d", r), 320'(round_const(4'(r))), 320'(CONST_TAB[r]));

    for (int k = 0; k < 4; k++) run_vec(k);

    // start held high: restart in the done cycle, input changes during RUN ignored
    a = vecs[2].init;
    b = vecs[1].init;
    @(negedge clock_i);
    start_i  = 1'b1;
    mode_i   = 1'b1;
    state_in = a;
    @(negedge clock_i);
    state_in = b;
    dones = 0; busy_cnt = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        if (dones == 0) begin
          d1 = c; r1 = state_out;
        end else if (dones == 1) begin
          d2 = c; r2 = state_out; start_i = 1'b0;
        end
        dones++;
      end
      @(negedge clock_i);
    end
    start_i = 1'b0;
    check("held first_done_at", 320'(d1), 320'(7));
    check("held first_result", r1, model_perm(a, 6));
    check("held second_done_at", 320'(d2), 320'(14));
    check("held second_result", r2, model_perm(b, 6));
    check("held busy_cycles", 320'(busy_cnt), 320'(12));
    check("held done_pulses", 320'(dones), 320'(2));

    // reset in the middle of a p^12 run
    @(negedge clock_i);
    start_i  = 1'b1;
    mode_i   = 1'b0;
    state_in = vecs[2].init;
    @(negedge clock_i);
    start_i = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (busy && round == 4'd5) found = 1;
      else @(negedge clock_i);
    end
    check("midreset reached_round5", 320'(found), 320'(1));
    resetb_i = 1'b0;
    @(negedge clock_i);
    resetb_i = 1'b1;
    check("midreset state_o", state_out, '0);
    check("midreset busy", 320'(busy), 320'(0));
    check("midreset round", 320'(round), 320'(0));
    check("midreset done", 320'(done), 320'(0));
    dones = 0; busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock_i);
      if (done) dones++;
      if (busy) busy_cnt++;
    end
    check("midreset no_done", 320'(dones), 320'(0));
    check("midreset stays_idle", 320'(busy_cnt), 320'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
